// File: rtl/bru_defs.sv
// Shared definitions for the branch resolve unit.
// Holds the default PC width, the instruction size used for fall-through,
// the FSM state encoding and the queue entry layout
// {pc, pred_taken, pred_target}, which is 2*XLEN+1 bits wide.
package bru_defs;

    localparam int BRU_XLEN    = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } bru_state_e;

    // Entry layout at the default XLEN. The top redeclares the same field
    // order locally so that a non-default XLEN works too.
    typedef struct packed {
        logic [BRU_XLEN-1:0] pc;
        logic                pred_taken;
        logic [BRU_XLEN-1:0] pred_target;
    } bru_entry_t;

    function automatic int entry_width(input int xlen);
        return 2 * xlen + 1;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bus between the branch resolve unit and fetch / execute / predictor.
// slave  : the resolve unit side (consumes push/resolve, drives update/flush)
// master : the environment side (fetch, execute, predictor)
// Signals: push_* from fetch, res_* from execute, upd_* to the predictor,
// flush/redirect_pc to fetch, res_underflow as an error pulse, count as
// queue occupancy.
interface branch_resolve_unit_if #(
    parameter int XLEN     = 32,
    parameter int PTR_BITS = 2
);
    logic            push_valid;
    logic            push_ready;
    logic [XLEN-1:0] push_pc;
    logic            push_pred_taken;
    logic [XLEN-1:0] push_pred_target;
    logic            res_valid;
    logic            res_taken;
    logic [XLEN-1:0] res_target;
    logic            upd_valid;
    logic            upd_taken;
    logic [XLEN-1:0] upd_pc;
    logic            flush;
    logic [XLEN-1:0] redirect_pc;
    logic            res_underflow;
    logic [PTR_BITS:0] count;

    modport slave (
        input  push_valid, push_pc, push_pred_taken, push_pred_target,
        input  res_valid, res_taken, res_target,
        output push_ready, upd_valid, upd_taken, upd_pc,
        output flush, redirect_pc, res_underflow, count
    );

    modport master (
        output push_valid, push_pc, push_pred_taken, push_pred_target,
        output res_valid, res_taken, res_target,
        input  push_ready, upd_valid, upd_taken, upd_pc,
        input  flush, redirect_pc, res_underflow, count
    );
endinterface

// File: rtl/bru_fifo.sv
// Synchronous DEPTH-entry circular FIFO for in-flight branch records.
// Ports: clk, rst (sync active-high), clear (drop all entries), push/din,
// pop, dout (entry at read pointer, valid when !empty), count, empty, full.
// The caller guarantees push only when !full and pop only when !empty;
// same-cycle push and pop leave count unchanged.
module bru_fifo #(
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = 2,
    parameter int W        = 65
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [W-1:0]      din,
    input  logic              pop,
    output logic [W-1:0]      dout,
    output logic [PTR_BITS:0] count,
    output logic              empty,
    output logic              full
);
    localparam logic [PTR_BITS:0]   DEPTH_C = (PTR_BITS+1)'(DEPTH);
    localparam logic [PTR_BITS:0]   CNT_ONE = (PTR_BITS+1)'(1);
    localparam logic [PTR_BITS-1:0] PTR_ONE = PTR_BITS'(1);

    logic [W-1:0]          mem [DEPTH];
    logic [PTR_BITS-1:0]   rd_ptr, wr_ptr;
    logic [PTR_BITS:0]     cnt_q;

    assign dout  = mem[rd_ptr];
    assign count = cnt_q;
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == DEPTH_C);

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues every predicted branch from fetch in order,
// compares the oldest one against the outcome from execute, updates the
// 2-bit-counter predictor and flushes/redirects fetch on a mispredict.
// Ports: clk, rst_n (synchronous, active-HIGH despite the name),
// bus (branch_resolve_unit_if.slave).
// Optional: define BRU_STATS_EN to add stat_resolved / stat_mispredict
// free-running 32-bit counters.
module branch_resolve_unit
    import bru_defs::*;
#(
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = 2,
    parameter int XLEN     = BRU_XLEN
) (
    input  logic clk,
    input  logic rst_n,
    branch_resolve_unit_if.slave bus
`ifdef BRU_STATS_EN
    ,
    output logic [31:0] stat_resolved,
    output logic [31:0] stat_mispredict
`endif
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            pred_taken;
        logic [XLEN-1:0] pred_target;
    } entry_t;

    localparam int EW = $bits(entry_t);

    bru_state_e        state_q, state_d;
    entry_t            push_entry, head;
    logic [EW-1:0]     head_raw;
    logic [PTR_BITS:0] count;
    logic              empty, full;
    logic              push_ready;
    logic              res_fire, mispredict, mis_fire, underflow;
    logic              fifo_push, fifo_pop;

    logic              upd_valid_q, upd_taken_q, flush_q, underflow_q;
    logic [XLEN-1:0]   upd_pc_q, redirect_q;

    assign push_entry = '{pc:          bus.push_pc,
                          pred_taken:  bus.push_pred_taken,
                          pred_target: bus.push_pred_target};
    assign head = head_raw;

    // Depends only on state and occupancy, so a same-cycle resolve never
    // opens a slot while full.
    assign push_ready = (state_q == RUN) && !full;

    // Resolves are ignored entirely during the flush cycle.
    assign res_fire  = (state_q == RUN) && bus.res_valid && !empty;
    assign underflow = (state_q == RUN) && bus.res_valid &&  empty;

    assign mispredict = (head.pred_taken != bus.res_taken) ||
                        (bus.res_taken && (head.pred_target != bus.res_target));
    assign mis_fire   = res_fire && mispredict;

    // A mispredict clears the whole queue, so a same-cycle push is dropped
    // and the pop is subsumed by the clear.
    assign fifo_push = bus.push_valid && push_ready && !mis_fire;
    assign fifo_pop  = res_fire && !mispredict;

    bru_fifo #(
        .DEPTH    (DEPTH),
        .PTR_BITS (PTR_BITS),
        .W        (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst_n),
        .clear (mis_fire),
        .push  (fifo_push),
        .din   (push_entry),
        .pop   (fifo_pop),
        .dout  (head_raw),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clk) begin
        if (rst_n) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (mis_fire) state_d = FLUSH;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            upd_valid_q <= 1'b0;
            upd_taken_q <= 1'b0;
            upd_pc_q    <= '0;
            flush_q     <= 1'b0;
            redirect_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            upd_valid_q <= res_fire;
            flush_q     <= mis_fire;
            underflow_q <= underflow;
            if (res_fire) begin
                upd_pc_q    <= head.pc;
                upd_taken_q <= bus.res_taken;
            end
            if (mis_fire)
                redirect_q <= bus.res_taken ? bus.res_target
                                            : head.pc + XLEN'(INSTR_BYTES);
        end
    end

`ifdef BRU_STATS_EN
    always_ff @(posedge clk) begin
        if (rst_n) begin
            stat_resolved   <= '0;
            stat_mispredict <= '0;
        end else begin
            if (res_fire) stat_resolved   <= stat_resolved + 32'd1;
            if (mis_fire) stat_mispredict <= stat_mispredict + 32'd1;
        end
    end
`endif

    assign bus.push_ready    = push_ready;
    assign bus.upd_valid     = upd_valid_q;
    assign bus.upd_taken     = upd_taken_q;
    assign bus.upd_pc        = upd_pc_q;
    assign bus.flush         = flush_q;
    assign bus.redirect_pc   = redirect_q;
    assign bus.res_underflow = underflow_q;
    assign bus.count         = count;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit.
module tb_branch_resolve_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.XLEN(32), .PTR_BITS(2)) bus ();

`ifdef BRU_STATS_EN
    logic [31:0] stat_resolved, stat_mispredict;
`endif

    branch_resolve_unit #(.DEPTH(4), .PTR_BITS(2), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef BRU_STATS_EN
        ,
        .stat_resolved   (stat_resolved),
        .stat_mispredict (stat_mispredict)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic v, input logic [31:0] pc,
                              input logic pt, input logic [31:0] tgt);
        bus.push_valid       = v;
        bus.push_pc          = pc;
        bus.push_pred_taken  = pt;
        bus.push_pred_target = tgt;
    endtask

    task automatic drive_res(input logic v, input logic t, input logic [31:0] tgt);
        bus.res_valid  = v;
        bus.res_taken  = t;
        bus.res_target = tgt;
    endtask

    task automatic test_reset();
        drive_push(0, 0, 0, 0);
        drive_res(0, 0, 0);
        rst_n = 1'b1;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        checks++; if (bus.upd_valid !== 1'b0) begin failures++; $display("FAIL rst_upd_valid got=%0h exp=0", bus.upd_valid); end
        checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL rst_flush got=%0h exp=0", bus.flush); end
        checks++; if (bus.res_underflow !== 1'b0) begin failures++; $display("FAIL rst_underflow got=%0h exp=0", bus.res_underflow); end
        checks++; if (bus.upd_pc !== 32'h0 || bus.redirect_pc !== 32'h0 || bus.upd_taken !== 1'b0) begin
            failures++; $display("FAIL rst_regs upd_pc=%h redirect=%h taken=%0h exp=0", bus.upd_pc, bus.redirect_pc, bus.upd_taken); end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
        checks++; if (bus.push_ready !== 1'b1) begin failures++; $display("FAIL rst_push_ready got=%0h exp=1", bus.push_ready); end
    endtask

    task automatic test_correct();
        drive_push(1, 32'h100, 0, 32'h0);
        tick();
        drive_push(0, 0, 0, 0);
        checks++; if (bus.count !== 3'd1) begin failures++; $display("FAIL corr_count1 got=%0d exp=1", bus.count); end
        drive_res(1, 0, 32'h0);
        tick();
        drive_res(0, 0, 0);
        checks++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== 32'h100 || bus.upd_taken !== 1'b0) begin
            failures++; $display("FAIL corr_upd v=%0h pc=%h t=%0h exp v=1 pc=100 t=0", bus.upd_valid, bus.upd_pc, bus.upd_taken); end
        checks++; if (bus.flush !== 1'b0 || bus.count !== 3'd0) begin
            failures++; $display("FAIL corr_flush_count flush=%0h count=%0d exp 0/0", bus.flush, bus.count); end
        tick();
        checks++; if (bus.upd_valid !== 1'b0 || bus.upd_pc !== 32'h100) begin
            failures++; $display("FAIL corr_pulse v=%0h pc=%h exp v=0 pc=100", bus.upd_valid, bus.upd_pc); end
    endtask

    task automatic test_mispredict_dir();
        drive_push(1, 32'h200, 0, 32'h0);
        tick();
        drive_push(0, 0, 0, 0);
        drive_res(1, 1, 32'h400);
        tick();
        checks++; if (bus.flush !== 1'b1 || bus.redirect_pc !== 32'h400 || bus.upd_taken !== 1'b1 || bus.upd_pc !== 32'h200) begin
            failures++; $display("FAIL dir_flush f=%0h rd=%h t=%0h pc=%h exp 1/400/1/200", bus.flush, bus.redirect_pc, bus.upd_taken, bus.upd_pc); end
        checks++; if (bus.push_ready !== 1'b0) begin failures++; $display("FAIL dir_ready_flush got=%0h exp=0", bus.push_ready); end
        // push and resolve during the flush cycle must both be ignored
        drive_push(1, 32'h300, 0, 32'h0);
        drive_res(1, 0, 32'h0);
        tick();
        drive_push(0, 0, 0, 0);
        drive_res(0, 0, 0);
        checks++; if (bus.flush !== 1'b0 || bus.upd_valid !== 1'b0 || bus.res_underflow !== 1'b0) begin
            failures++; $display("FAIL dir_after f=%0h v=%0h uf=%0h exp 0/0/0", bus.flush, bus.upd_valid, bus.res_underflow); end
        checks++; if (bus.push_ready !== 1'b1 || bus.count !== 3'd0 || bus.redirect_pc !== 32'h400) begin
            failures++; $display("FAIL dir_run rdy=%0h cnt=%0d rd=%h exp 1/0/400", bus.push_ready, bus.count, bus.redirect_pc); end
    endtask

    task automatic test_full();
        logic [31:0] exp_pc [5];
        exp_pc[0] = 32'h10; exp_pc[1] = 32'h20; exp_pc[2] = 32'h30;
        exp_pc[3] = 32'h40; exp_pc[4] = 32'h50;
        for (int i = 0; i < 4; i++) begin
            drive_push(1, exp_pc[i], 1, 32'h80);
            tick();
        end
        checks++; if (bus.count !== 3'd4 || bus.push_ready !== 1'b0) begin
            failures++; $display("FAIL full_state cnt=%0d rdy=%0h exp 4/0", bus.count, bus.push_ready); end
        // full: same-cycle resolve must not let the 5th push in
        drive_push(1, 32'h50, 1, 32'h80);
        drive_res(1, 1, 32'h80);
        tick();
        checks++; if (bus.count !== 3'd3 || bus.upd_pc !== 32'h10 || bus.upd_valid !== 1'b1 || bus.flush !== 1'b0) begin
            failures++; $display("FAIL full_block cnt=%0d pc=%h v=%0h f=%0h exp 3/10/1/0", bus.count, bus.upd_pc, bus.upd_valid, bus.flush); end
        // not full: push and resolve together keep count
        tick();
        drive_push(0, 0, 0, 0);
        checks++; if (bus.count !== 3'd3 || bus.upd_pc !== 32'h20 || bus.upd_taken !== 1'b1) begin
            failures++; $display("FAIL pushpop cnt=%0d pc=%h t=%0h exp 3/20/1", bus.count, bus.upd_pc, bus.upd_taken); end
        for (int i = 2; i < 5; i++) begin
            tick();
            checks++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== exp_pc[i] || bus.flush !== 1'b0) begin
                failures++; $display("FAIL order_%0d v=%0h pc=%h exp 1/%h", i, bus.upd_valid, bus.upd_pc, exp_pc[i]); end
        end
        drive_res(0, 0, 0);
        tick();
        checks++; if (bus.count !== 3'd0 || bus.upd_valid !== 1'b0) begin
            failures++; $display("FAIL full_drain cnt=%0d v=%0h exp 0/0", bus.count, bus.upd_valid); end
    endtask

    task automatic test_mispredict_target();
        drive_push(1, 32'h500, 1, 32'h600);
        tick();
        drive_push(1, 32'h700, 0, 32'h0);
        tick();
        drive_push(1, 32'h780, 0, 32'h0);
        tick();
        drive_push(0, 0, 0, 0);
        checks++; if (bus.count !== 3'd3) begin failures++; $display("FAIL tgt_count got=%0d exp=3", bus.count); end
        drive_res(1, 1, 32'h604);
        tick();
        drive_res(0, 0, 0);
        checks++; if (bus.flush !== 1'b1 || bus.redirect_pc !== 32'h604 || bus.upd_pc !== 32'h500 || bus.count !== 3'd0) begin
            failures++; $display("FAIL tgt_flush f=%0h rd=%h pc=%h cnt=%0d exp 1/604/500/0", bus.flush, bus.redirect_pc, bus.upd_pc, bus.count); end
        tick();
        // predicted taken, actually not taken: fall through to pc+4
        drive_push(1, 32'h800, 1, 32'h900);
        tick();
        drive_push(0, 0, 0, 0);
        drive_res(1, 0, 32'h0);
        tick();
        drive_res(0, 0, 0);
        checks++; if (bus.flush !== 1'b1 || bus.redirect_pc !== 32'h804 || bus.upd_taken !== 1'b0) begin
            failures++; $display("FAIL nt_redirect f=%0h rd=%h t=%0h exp 1/804/0", bus.flush, bus.redirect_pc, bus.upd_taken); end
        tick();
        // pc+4 wraps at the top of the address space
        drive_push(1, 32'hFFFF_FFFC, 1, 32'h10);
        tick();
        drive_push(0, 0, 0, 0);
        drive_res(1, 0, 32'h0);
        tick();
        drive_res(0, 0, 0);
        checks++; if (bus.flush !== 1'b1 || bus.redirect_pc !== 32'h0) begin
            failures++; $display("FAIL wrap_redirect f=%0h rd=%h exp 1/0", bus.flush, bus.redirect_pc); end
        tick();
    endtask

    task automatic test_underflow();
        drive_res(1, 0, 32'h0);
        tick();
        drive_res(0, 0, 0);
        checks++; if (bus.res_underflow !== 1'b1 || bus.upd_valid !== 1'b0) begin
            failures++; $display("FAIL uf_pulse uf=%0h v=%0h exp 1/0", bus.res_underflow, bus.upd_valid); end
        tick();
        checks++; if (bus.res_underflow !== 1'b0) begin failures++; $display("FAIL uf_clear got=%0h exp=0", bus.res_underflow); end
        // resolve with a same-cycle push into an empty queue still underflows
        drive_push(1, 32'hA00, 0, 32'h0);
        drive_res(1, 0, 32'h0);
        tick();
        drive_push(0, 0, 0, 0);
        drive_res(0, 0, 0);
        checks++; if (bus.res_underflow !== 1'b1 || bus.upd_valid !== 1'b0 || bus.count !== 3'd1) begin
            failures++; $display("FAIL uf_push uf=%0h v=%0h cnt=%0d exp 1/0/1", bus.res_underflow, bus.upd_valid, bus.count); end
        drive_res(1, 0, 32'h0);
        tick();
        drive_res(0, 0, 0);
        checks++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== 32'hA00 || bus.count !== 3'd0) begin
            failures++; $display("FAIL uf_drain v=%0h pc=%h cnt=%0d exp 1/a00/0", bus.upd_valid, bus.upd_pc, bus.count); end
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive_push(1, 32'hC00 + 32'(i * 16), 0, 32'h0);
            tick();
        end
        drive_push(0, 0, 0, 0);
        checks++; if (bus.count !== 3'd3) begin failures++; $display("FAIL mid_count got=%0d exp=3", bus.count); end
        rst_n = 1'b1;
        drive_res(1, 1, 32'hDEAD);
        tick();
        drive_res(0, 0, 0);
        checks++; if (bus.count !== 3'd0 || bus.upd_valid !== 1'b0 || bus.flush !== 1'b0 || bus.upd_pc !== 32'h0) begin
            failures++; $display("FAIL mid_rst cnt=%0d v=%0h f=%0h pc=%h exp 0/0/0/0", bus.count, bus.upd_valid, bus.flush, bus.upd_pc); end
        rst_n = 1'b0;
        tick();
        checks++; if (bus.upd_valid !== 1'b0 || bus.flush !== 1'b0 || bus.push_ready !== 1'b1) begin
            failures++; $display("FAIL mid_after v=%0h f=%0h rdy=%0h exp 0/0/1", bus.upd_valid, bus.flush, bus.push_ready); end
        drive_res(1, 0, 32'h0);
        tick();
        drive_res(0, 0, 0);
        checks++; if (bus.res_underflow !== 1'b1 || bus.upd_valid !== 1'b0) begin
            failures++; $display("FAIL mid_empty uf=%0h v=%0h exp 1/0", bus.res_underflow, bus.upd_valid); end
        tick();
    endtask

    initial begin
        drive_push(0, 0, 0, 0);
        drive_res(0, 0, 0);
        test_reset();
        test_correct();
        test_mispredict_dir();
        test_full();
        test_mispredict_target();
        test_underflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
